// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants: default 800x600 @ 60 Hz (40 MHz pclk) mode,
// derived totals and sync window bounds, reused by downstream drawing stages.
package vga_timing_gen_pkg;

    // Counter width and the largest total it can represent.
    localparam int unsigned CNT_W     = 11;
    localparam int unsigned MAX_TOTAL = 2048;

    typedef logic [CNT_W-1:0] count_t;

    // Default horizontal timing (pixels).
    localparam int unsigned DEF_H_VISIBLE = 800;
    localparam int unsigned DEF_H_FRONT   = 40;
    localparam int unsigned DEF_H_SYNC    = 128;
    localparam int unsigned DEF_H_BACK    = 88;
    localparam int unsigned DEF_H_TOTAL   =
        DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;

    // Default vertical timing (lines).
    localparam int unsigned DEF_V_VISIBLE = 600;
    localparam int unsigned DEF_V_FRONT   = 1;
    localparam int unsigned DEF_V_SYNC    = 4;
    localparam int unsigned DEF_V_BACK    = 23;
    localparam int unsigned DEF_V_TOTAL   =
        DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int unsigned DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    // Default sync polarities (1 = active-high).
    localparam bit DEF_H_SYNC_POL = 1'b1;
    localparam bit DEF_V_SYNC_POL = 1'b1;

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. All outputs are registered and computed from the
// next (hcount, vcount) pair, so counts, sync, blank and strobes never skew.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT    = DEF_H_FRONT,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BACK     = DEF_H_BACK,
    parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT    = DEF_V_FRONT,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BACK     = DEF_V_BACK,
    parameter bit          H_SYNC_POL = DEF_H_SYNC_POL,
    parameter bit          V_SYNC_POL = DEF_V_SYNC_POL
) (
    input  logic             pclk,
    input  logic             rst,
    output logic [CNT_W-1:0] hcount_out,
    output logic             hsync_out,
    output logic             hblnk_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             vsync_out,
    output logic             vblnk_out,
    output logic             frame_start,
    output logic             line_end
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Totals must fit the 11-bit counters; refuse to elaborate otherwise.
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL || H_TOTAL == 0 || V_TOTAL == 0)
    begin : g_total_guard
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must be in 1..2048");
    end

    // Bounds are kept 12 bits wide: a sync end may equal 2048, one past the
    // largest 11-bit count.
    localparam logic [CNT_W:0] H_LAST_W     = (CNT_W+1)'(H_TOTAL - 1);
    localparam logic [CNT_W:0] H_VIS_W      = (CNT_W+1)'(H_VISIBLE);
    localparam logic [CNT_W:0] H_SYNC_BEG_W = (CNT_W+1)'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W:0] H_SYNC_END_W = (CNT_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W:0] V_LAST_W     = (CNT_W+1)'(V_TOTAL - 1);
    localparam logic [CNT_W:0] V_VIS_W      = (CNT_W+1)'(V_VISIBLE);
    localparam logic [CNT_W:0] V_SYNC_BEG_W = (CNT_W+1)'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W:0] V_SYNC_END_W = (CNT_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

    count_t hcount_q, hcount_d;
    count_t vcount_q, vcount_d;
    logic   hsync_q, hsync_d;
    logic   hblnk_q, hblnk_d;
    logic   vsync_q, vsync_d;
    logic   vblnk_q, vblnk_d;
    logic   frame_start_q, frame_start_d;
    logic   line_end_q, line_end_d;
    logic   h_wrap, v_wrap;

    // Next-state for both counters and every flag, derived from the next counts.
    always_comb begin
        h_wrap        = ({1'b0, hcount_q} == H_LAST_W);
        v_wrap        = ({1'b0, vcount_q} == V_LAST_W);
        hcount_d      = h_wrap ? '0 : hcount_q + count_t'(1);
        vcount_d      = vcount_q;
        if (h_wrap) begin
            vcount_d = v_wrap ? '0 : vcount_q + count_t'(1);
        end
        hblnk_d       = ({1'b0, hcount_d} >= H_VIS_W);
        hsync_d       = ~H_SYNC_POL;
        if ({1'b0, hcount_d} >= H_SYNC_BEG_W && {1'b0, hcount_d} < H_SYNC_END_W) begin
            hsync_d = H_SYNC_POL;
        end
        vblnk_d       = ({1'b0, vcount_d} >= V_VIS_W);
        vsync_d       = ~V_SYNC_POL;
        if ({1'b0, vcount_d} >= V_SYNC_BEG_W && {1'b0, vcount_d} < V_SYNC_END_W) begin
            vsync_d = V_SYNC_POL;
        end
        line_end_d    = ({1'b0, hcount_d} == H_LAST_W);
        // Only a real wrap raises the strobe; the (0,0) of reset never does.
        frame_start_d = h_wrap && v_wrap;
    end

    // Horizontal state: pixel counter plus its per-pixel flags.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_q   <= '0;
            hsync_q    <= ~H_SYNC_POL;
            hblnk_q    <= 1'b0;
            line_end_q <= 1'b0;
        end else begin
            hcount_q   <= hcount_d;
            hsync_q    <= hsync_d;
            hblnk_q    <= hblnk_d;
            line_end_q <= line_end_d;
        end
    end

    // Vertical state: line counter, per-line flags and the frame strobe.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vcount_q      <= '0;
            vsync_q       <= ~V_SYNC_POL;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            vcount_q      <= vcount_d;
            vsync_q       <= vsync_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount_out  = hcount_q;
    assign hsync_out   = hsync_q;
    assign hblnk_out   = hblnk_q;
    assign vcount_out  = vcount_q;
    assign vsync_out   = vsync_q;
    assign vblnk_out   = vblnk_q;
    assign frame_start = frame_start_q;
    assign line_end    = line_end_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-mode instance plus two small-mode instances
// (both sync polarities) checked every cycle against an elapsed-time raster model.
module tb_vga_timing_gen;

    // Small mode so whole frames fit in a short run: 19 x 12 = 228 pclk per frame.
    localparam int SHV = 10, SHF = 2, SHS = 3, SHB = 4;
    localparam int SVV = 6,  SVF = 1, SVS = 2, SVB = 3;
    localparam int S_HT = SHV + SHF + SHS + SHB;
    localparam int S_VT = SVV + SVF + SVS + SVB;

    logic        pclk, rst;
    logic [10:0] d_hc, d_vc, s_hc, s_vc, i_hc, i_vc;
    logic        d_hs, d_hb, d_vs, d_vb, d_fs, d_le;
    logic        s_hs, s_hb, s_vs, s_vb, s_fs, s_le;
    logic        i_hs, i_hb, i_vs, i_vb, i_fs, i_le;

    int     n_checks = 0;
    int     n_errors = 0;
    longint model_t  = 0;   // pclk cycles since reset released (0 while in reset)
    longint cyc      = 0;
    longint d_le_prev = -1, s_fs_prev = -1;
    int     d_hs_run = 0, s_vs_run = 0;

    vga_timing_gen u_dut_def (
        .pclk(pclk), .rst(rst),
        .hcount_out(d_hc), .hsync_out(d_hs), .hblnk_out(d_hb),
        .vcount_out(d_vc), .vsync_out(d_vs), .vblnk_out(d_vb),
        .frame_start(d_fs), .line_end(d_le)
    );

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) u_dut_small (
        .pclk(pclk), .rst(rst),
        .hcount_out(s_hc), .hsync_out(s_hs), .hblnk_out(s_hb),
        .vcount_out(s_vc), .vsync_out(s_vs), .vblnk_out(s_vb),
        .frame_start(s_fs), .line_end(s_le)
    );

    vga_timing_gen #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
    ) u_dut_inv (
        .pclk(pclk), .rst(rst),
        .hcount_out(i_hc), .hsync_out(i_hs), .hblnk_out(i_hb),
        .vcount_out(i_vc), .vsync_out(i_vs), .vblnk_out(i_vb),
        .frame_start(i_fs), .line_end(i_le)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected raster position and flags follow directly from elapsed time.
    task automatic check_dut(input string name,
                             input int hv, input int hf, input int hs, input int hb,
                             input int vv, input int vf, input int vs, input int vb,
                             input bit hp, input bit vp,
                             input logic [10:0] hc, input logic [10:0] vc,
                             input logic hsy, input logic hbl, input logic vsy,
                             input logic vbl, input logic fs, input logic le);
        longint ht, vt, eh, ev;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        eh = model_t % ht;
        ev = (model_t / ht) % vt;
        check({name, ".hcount"}, hc, eh);
        check({name, ".vcount"}, vc, ev);
        check({name, ".hblnk"}, hbl, (eh >= hv) ? 1 : 0);
        check({name, ".vblnk"}, vbl, (ev >= vv) ? 1 : 0);
        check({name, ".hsync"}, hsy, (eh >= hv + hf && eh < hv + hf + hs) ? hp : !hp);
        check({name, ".vsync"}, vsy, (ev >= vv + vf && ev < vv + vf + vs) ? vp : !vp);
        check({name, ".line_end"}, le, (eh == ht - 1) ? 1 : 0);
        check({name, ".frame_start"}, fs, (model_t > 0 && eh == 0 && ev == 0) ? 1 : 0);
    endtask

    // One pclk: advance the model, sample outputs 1 time unit after the edge.
    task automatic step();
        @(posedge pclk);
        if (rst) model_t = 0;
        else     model_t++;
        cyc++;
        #1;
        check_dut("def", 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1,
                  d_hc, d_vc, d_hs, d_hb, d_vs, d_vb, d_fs, d_le);
        check_dut("small", SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b1, 1'b1,
                  s_hc, s_vc, s_hs, s_hb, s_vs, s_vb, s_fs, s_le);
        check_dut("inv", SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b0, 1'b0,
                  i_hc, i_vc, i_hs, i_hb, i_vs, i_vb, i_fs, i_le);
        if (rst) begin
            d_le_prev = -1;
            s_fs_prev = -1;
            d_hs_run  = 0;
            s_vs_run  = 0;
        end else begin
            // Period invariants measured purely from the DUT strobes.
            if (d_le) begin
                if (d_le_prev >= 0) check("def.line_period", cyc - d_le_prev, 1056);
                d_le_prev = cyc;
            end
            if (s_fs) begin
                if (s_fs_prev >= 0) check("small.frame_period", cyc - s_fs_prev, S_HT * S_VT);
                s_fs_prev = cyc;
            end
            if (d_hs) d_hs_run++;
            else if (d_hs_run > 0) begin
                check("def.hsync_width", d_hs_run, 128);
                d_hs_run = 0;
            end
            if (s_vs) s_vs_run++;
            else if (s_vs_run > 0) begin
                check("small.vsync_width", s_vs_run, SVS * S_HT);
                s_vs_run = 0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        // Long clean run: several small frames and two default line wraps.
        repeat (2300) step();

        // Directed mid-frame reset in the small raster at (5,3).
        for (int k = 0; k < 2 * S_HT * S_VT; k++) begin
            if ((model_t % S_HT) == 5 && ((model_t / S_HT) % S_VT) == 3) break;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3 * S_HT * S_VT) step();

        // Randomized reset pulses at random points of the raster.
        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(1, 700)) step();
            rst = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            rst = 1'b0;
        end
        repeat (1500) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
